decoder_n_seq: RTL and testbench
================================

DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 SHALL have parameter SEL_W, default 5, giving the select width (32 outputs for the register file).
REQ-002 SHALL have localparam OUT_W = 2**SEL_W, the one-hot output width; it SHALL NOT be overridable.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  clock enable; 0 freezes all state except wrap.
REQ-006 SHALL have port start  input  1  begin or retarget an operation; samples mode and sel.
REQ-007 SHALL have port stop  input  1  return to IDLE.
REQ-008 SHALL have port mode  input  2  operation: 00 decode-hold, 01 scan-up, 10 scan-down, 11 decode-hold.
REQ-009 SHALL have port sel  input  SEL_W  target or starting index.
REQ-010 SHALL have port y  output  OUT_W  registered one-hot decode of idx.
REQ-011 SHALL have port idx  output  SEL_W  registered current index.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse on a scan wrap-around.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, HOLD and SCAN; the scan direction (up or down) SHALL be held in a register.
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 In IDLE, y SHALL be all zeros, idx SHALL be 0 and busy SHALL be 0.
REQ-017 In HOLD and SCAN, y SHALL equal 1<<idx (exactly one bit set) and busy SHALL be 1.
REQ-018 Sampling rule: an input is acted on only at an edge where en=1; when en=0, state, idx, y and direction SHALL NOT change.
REQ-019 start=1 with stop=0, in any state: mode 00 or 11 SHALL go to HOLD and mode 01 or 10 SHALL go to SCAN, with idx=sel and direction taken from mode; y SHALL be valid at the edge following the sampling edge (latency 1).
REQ-020 When stop=1, state SHALL go to IDLE, regardless of start (stop has priority); stop in IDLE has no effect.
REQ-021 HOLD with start=0 and stop=0: idx and y SHALL hold.
REQ-022 SCAN with start=0 and stop=0: each enabled edge SHALL step idx, +1 when up, -1 when down, modulo OUT_W.
REQ-023 wrap SHALL be 1 for exactly the cycle after a step from OUT_W-1 to 0 (up) or from 0 to OUT_W-1 (down), and 0 otherwise.
REQ-024 wrap SHALL be 0 after any edge with en=0, and after any start reload, even if the loaded sel is a boundary value.
REQ-025 A start while in SCAN SHALL reload idx from sel without stepping on that edge.
REQ-026 start in SCAN with mode 00 SHALL go to HOLD at sel.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, idx=0, y=0, busy=0, wrap=0 and direction=up.
REQ-028 Reset mid-operation (HOLD or SCAN) SHALL discard the operation; after release the block stays in IDLE until the next enabled start.
REQ-029 The first enabled edge after rst_n deasserts SHALL be processed normally.

Verification (SEL_W=5)
REQ-030 Decode: start, mode=00, sel=7 -> next cycle y=0x00000080, idx=7, busy=1; holds for 10 cycles; then stop -> y=0, busy=0.
REQ-031 Scan-up wrap: start, mode=01, sel=30 -> idx goes 30, 31, 0, 1; wrap=1 only in the cycle idx=0; y=0x00000001 in that cycle.
REQ-032 Scan-down wrap with en gap: start, mode=10, sel=1 -> idx 1, 0, 31; with en=0 for 3 cycles idx stays 31 and wrap=0; en=1 -> idx 30.
REQ-033 Priority and retarget: in SCAN at idx=12, start with sel=3 and mode=00 -> HOLD, idx=3; start and stop together -> IDLE, y=0.
REQ-034 Async reset: rst_n pulsed low mid-cycle during SCAN at idx=20 -> y=0, idx=0, busy=0 before the next clk edge; outputs remain 0 until the next start.

Source files
------------

// File: rtl/decoder_n_seq.sv
// Sequenced one-hot decoder: holds a decoded index or scans it up/down with a wrap pulse.
// All outputs are registered; the clock enable freezes everything except the wrap pulse.
module decoder_n_seq #(
   parameter int SEL_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    start,
   input  logic                    stop,
   input  logic [1:0]              mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [(2**SEL_W)-1:0]   y,
   output logic [SEL_W-1:0]        idx,
   output logic                    busy,
   output logic                    wrap
);

   localparam int OUT_W = 2**SEL_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             dir_down, dir_down_nxt;
   logic [SEL_W-1:0] idx_nxt;
   logic             wrap_nxt;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt    = state;
      dir_down_nxt = dir_down;
      idx_nxt      = idx;
      wrap_nxt     = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
      end else if (start) begin
         // A reload never steps and never pulses wrap, even at a boundary sel.
         state_nxt    = (mode == 2'b01 || mode == 2'b10) ? SCAN : HOLD;
         dir_down_nxt = (mode == 2'b10);
         idx_nxt      = sel;
      end else if (state == SCAN) begin
         if (dir_down) begin
            wrap_nxt = (idx == '0);
            idx_nxt  = idx - 1'b1;
         end else begin
            wrap_nxt = (idx == '1);
            idx_nxt  = idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state    <= IDLE;
         dir_down <= 1'b0;
         idx      <= '0;
         y        <= '0;
         busy     <= 1'b0;
         wrap     <= 1'b0;
      end else if (en) begin
         state    <= state_nxt;
         dir_down <= dir_down_nxt;
         idx      <= idx_nxt;
         y        <= (state_nxt == IDLE) ? '0 : (OUT_W'(1) << idx_nxt);
         busy     <= (state_nxt != IDLE);
         wrap     <= wrap_nxt;
      end else begin
         wrap     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decoder_n_seq.sv
// Bench for decoder_n_seq: directed vector table, randomized run against a model, async reset.
module tb_decoder_n_seq;

   localparam int SEL_W = 5;
   localparam int OUT_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en, start, stop;
   logic [1:0]       mode;
   logic [SEL_W-1:0] sel;
   logic [OUT_W-1:0] y;
   logic [SEL_W-1:0] idx;
   logic             busy, wrap;

   int n_vec = 0;
   int n_bad = 0;

   decoder_n_seq #(.SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
      .mode(mode), .sel(sel), .y(y), .idx(idx), .busy(busy), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       en, start, stop;
      logic [1:0] mode;
      int         sel;
      int         eidx;
      bit         ebusy, ewrap;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic e, input logic st, input logic sp,
                      input logic [1:0] m, input int s, input int ei, input bit eb, input bit ew);
      vec_t v;
      v.name = name; v.en = e; v.start = st; v.stop = sp; v.mode = m; v.sel = s;
      v.eidx = ei; v.ebusy = eb; v.ewrap = ew;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input int eidx, input bit ebusy, input bit ewrap);
      logic [OUT_W-1:0] ey;
      ey = ebusy ? (OUT_W'(1) << eidx) : '0;
      check({tag, ".y"},    y,    ey);
      check({tag, ".idx"},  OUT_W'(idx),  OUT_W'(eidx));
      check({tag, ".busy"}, OUT_W'(busy), OUT_W'(ebusy));
      check({tag, ".wrap"}, OUT_W'(wrap), OUT_W'(ewrap));
   endtask

   task automatic drive(input logic e, input logic st, input logic sp, input logic [1:0] m, input int s);
      en = e; start = st; stop = sp; mode = m; sel = SEL_W'(s);
   endtask

   // Inputs change 1 ns after an edge; outputs are sampled there too, far from the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model state, kept as plain integers.
   int m_state;   // 0 idle, 1 hold, 2 scan
   int m_idx;
   bit m_up;
   bit m_wrap;

   task automatic model_edge(input logic e, input logic st, input logic sp, input logic [1:0] m, input int s);
      m_wrap = 1'b0;
      if (!e) return;
      if (sp) begin
         m_state = 0; m_idx = 0;
      end else if (st) begin
         m_state = (m == 2'd1 || m == 2'd2) ? 2 : 1;
         m_idx   = s;
         m_up    = (m != 2'd2);
      end else if (m_state == 2) begin
         if (m_up) begin
            m_wrap = (m_idx == OUT_W - 1);
            m_idx  = (m_idx + 1) % OUT_W;
         end else begin
            m_wrap = (m_idx == 0);
            m_idx  = (m_idx + OUT_W - 1) % OUT_W;
         end
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 2'd0, 0);
      rst_n = 1'b0;
      #2;
      check_outs("reset", 0, 1'b0, 1'b0);
      #10;
      rst_n = 1'b1;   // released mid-cycle
      step();
      check_outs("post_reset", 0, 1'b0, 1'b0);

      // Decode-hold at 7 for 10 cycles, then stop.
      add("hold_start", 1, 1, 0, 2'd0, 7, 7, 1, 0);
      for (int i = 0; i < 10; i++) add("hold_keep", 1, 0, 0, 2'd0, 0, 7, 1, 0);
      add("hold_stop",  1, 0, 1, 2'd0, 0, 0, 0, 0);
      add("idle_stop",  1, 0, 1, 2'd1, 9, 0, 0, 0);
      // Scan-up across the top.
      add("up_start",   1, 1, 0, 2'd1, 30, 30, 1, 0);
      add("up_31",      1, 0, 0, 2'd0, 0, 31, 1, 0);
      add("up_wrap",    1, 0, 0, 2'd0, 0, 0, 1, 1);
      add("up_1",       1, 0, 0, 2'd0, 0, 1, 1, 0);
      add("up_stop",    1, 0, 1, 2'd0, 0, 0, 0, 0);
      // Scan-down across zero, then an enable gap.
      add("dn_start",   1, 1, 0, 2'd2, 1, 1, 1, 0);
      add("dn_0",       1, 0, 0, 2'd0, 0, 0, 1, 0);
      add("dn_wrap",    1, 0, 0, 2'd0, 0, 31, 1, 1);
      for (int i = 0; i < 3; i++) add("dn_gap", 0, 0, 0, 2'd0, 0, 31, 1, 0);
      add("dn_30",      1, 0, 0, 2'd0, 0, 30, 1, 0);
      // Reloads at boundary values never pulse wrap.
      add("rl_31",      1, 1, 0, 2'd1, 31, 31, 1, 0);
      add("rl_0",       1, 1, 0, 2'd2, 0, 0, 1, 0);
      add("rl_step",    1, 0, 0, 2'd0, 0, 31, 1, 1);
      // Retarget to hold, then start+stop priority.
      add("rt_start",   1, 1, 0, 2'd1, 10, 10, 1, 0);
      add("rt_11",      1, 0, 0, 2'd0, 0, 11, 1, 0);
      add("rt_12",      1, 0, 0, 2'd0, 0, 12, 1, 0);
      add("rt_hold",    1, 1, 0, 2'd0, 3, 3, 1, 0);
      add("rt_keep",    1, 0, 0, 2'd0, 0, 3, 1, 0);
      add("rt_m11",     1, 1, 0, 2'd3, 17, 17, 1, 0);
      add("rt_keep17",  1, 0, 0, 2'd0, 0, 17, 1, 0);
      add("prio_stop",  1, 1, 1, 2'd1, 5, 0, 0, 0);
      add("gap_start",  0, 1, 0, 2'd1, 5, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].sel);
         step();
         check_outs(vecs[i].name, vecs[i].eidx, vecs[i].ebusy, vecs[i].ewrap);
      end

      // Randomized run from IDLE against the model.
      m_state = 0; m_idx = 0; m_up = 1'b1; m_wrap = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic       e, st, sp;
         logic [1:0] m;
         int         s;
         e  = ($urandom_range(0, 99) < 85);
         st = ($urandom_range(0, 99) < 15);
         sp = ($urandom_range(0, 99) < 5);
         m  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       s = 0;
            1:       s = OUT_W - 1;
            default: s = $urandom_range(0, OUT_W - 1);
         endcase
         drive(e, st, sp, m, s);
         model_edge(e, st, sp, m, s);
         step();
         check_outs("rand", m_idx, (m_state != 0), m_wrap);
      end

      // Async reset mid-cycle while scanning at 20.
      drive(1'b1, 1'b1, 1'b0, 2'd1, 15);
      step();
      drive(1'b1, 1'b0, 1'b0, 2'd0, 0);
      for (int i = 0; i < 5; i++) step();
      check_outs("scan_20", 20, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 0, 1'b0, 1'b0);
      step();
      check_outs("rst_held", 0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs("rst_idle", 0, 1'b0, 1'b0);
      end
      drive(1'b1, 1'b1, 1'b0, 2'd0, 5);
      step();
      check_outs("rst_restart", 5, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
